// File: rtl/rom_sequence_player_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rom_sequence_player_pkg
//  Brief    : Shared game constants: FSM state encoding and ROM geometry.
//  Revision : 1.0 - initial release
// ============================================================================
package rom_sequence_player_pkg;

    localparam int ROM_ADDR_W = 4;
    localparam int LED_W      = 7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_SHOW  = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

endpackage : rom_sequence_player_pkg
`default_nettype wire

// File: rtl/rom_sequence_player_if.sv
`default_nettype none
// ============================================================================
//  Module   : rom_sequence_player_if
//  Brief    : Handshake and ROM bus between game FSM, pattern ROM and player.
//  Revision : 1.0 - initial release
// ============================================================================
interface rom_sequence_player_if;
    import rom_sequence_player_pkg::*;

    logic                  start;
    logic                  abort;
    logic [ROM_ADDR_W-1:0] limit;
    logic [LED_W-1:0]      rom_data;
    logic [ROM_ADDR_W-1:0] rom_address;
    logic [LED_W-1:0]      leds;
    logic                  busy;
    logic                  done;

    // Environment side: game FSM commands plus the ROM read data.
    modport master (
        output start, abort, limit, rom_data,
        input  rom_address, leds, busy, done
    );

    // Player side.
    modport slave (
        input  start, abort, limit, rom_data,
        output rom_address, leds, busy, done
    );
endinterface : rom_sequence_player_if
`default_nettype wire

// File: rtl/rom_sequence_player_timer_down.sv
`default_nettype none
// ============================================================================
//  Module   : timer_down
//  Brief    : Loadable down-counter with zero flag; times on and off intervals.
//  Revision : 1.0 - initial release
// ============================================================================
module timer_down #(
    parameter int WIDTH = 8
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             load_i,
    input  wire logic [WIDTH-1:0] value_i,
    input  wire logic             dec_i,
    output logic                  zero_o
);

    logic [WIDTH-1:0] count_q;

    // Load has priority over decrement; the counter saturates at zero.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= value_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero_o = (count_q == '0);

endmodule : timer_down
`default_nettype wire

// File: rtl/sync_rom_16x4.sv
`default_nettype none
// ============================================================================
//  Module   : sync_rom_16x4
//  Brief    : 16-entry pattern ROM, one-hot 7-bit LED words, 1-cycle latency.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_rom_16x4
    import rom_sequence_player_pkg::*;
(
    input  wire logic                  clock,
    input  wire logic [ROM_ADDR_W-1:0] address,
    output logic      [LED_W-1:0]      data_out
);

    // Registered read: a sweep up, a sweep down, then a short tail.
    always_ff @(posedge clock) begin
        case (address)
            4'd0:    data_out <= 7'b0000001;
            4'd1:    data_out <= 7'b0000010;
            4'd2:    data_out <= 7'b0000100;
            4'd3:    data_out <= 7'b0001000;
            4'd4:    data_out <= 7'b0010000;
            4'd5:    data_out <= 7'b0100000;
            4'd6:    data_out <= 7'b1000000;
            4'd7:    data_out <= 7'b0100000;
            4'd8:    data_out <= 7'b0010000;
            4'd9:    data_out <= 7'b0001000;
            4'd10:   data_out <= 7'b0000100;
            4'd11:   data_out <= 7'b0000010;
            4'd12:   data_out <= 7'b0000001;
            4'd13:   data_out <= 7'b0000010;
            4'd14:   data_out <= 7'b0001000;
            default: data_out <= 7'b0000100;
        endcase
    end

endmodule : sync_rom_16x4
`default_nettype wire

// File: rtl/rom_sequence_player.sv
`default_nettype none
// ============================================================================
//  Module   : rom_sequence_player
//  Brief    : Plays ROM addresses 0..limit on the LEDs with fixed on/off times.
//  Revision : 1.0 - initial release
// ============================================================================
module rom_sequence_player
    import rom_sequence_player_pkg::*;
#(
    parameter int ON_CYCLES   = 4,
    parameter int OFF_CYCLES  = 2,
    parameter int TIMER_WIDTH = 8
) (
    input  wire logic          clock,
    input  wire logic          reset,
    rom_sequence_player_if.slave bus
);

    localparam logic [TIMER_WIDTH-1:0] c_on_load  = TIMER_WIDTH'(ON_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] c_off_load = TIMER_WIDTH'(OFF_CYCLES - 1);

    state_t                state_q;
    logic [ROM_ADDR_W-1:0] limit_q;
    logic [ROM_ADDR_W-1:0] rom_address_q;
    logic [ROM_ADDR_W-1:0] rom_address_d;
    logic [LED_W-1:0]      leds_q;
    logic                  busy_q;
    logic                  done_q;

    logic                   w_timer_load;
    logic                   w_timer_dec;
    logic [TIMER_WIDTH-1:0] w_timer_val;
    logic                   w_timer_zero;

    assign rom_address_d = rom_address_q + 1'b1;

    timer_down #(
        .WIDTH (TIMER_WIDTH)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .load_i  (w_timer_load),
        .value_i (w_timer_val),
        .dec_i   (w_timer_dec),
        .zero_o  (w_timer_zero)
    );

    // Timer control: load the on-time in LOAD, the off-time when SHOW expires.
    always_comb begin
        w_timer_load = 1'b0;
        w_timer_dec  = 1'b0;
        w_timer_val  = c_on_load;
        case (state_q)
            S_LOAD: begin
                w_timer_load = 1'b1;
                w_timer_val  = c_on_load;
            end
            S_SHOW: begin
                if (w_timer_zero) begin
                    w_timer_load = 1'b1;
                    w_timer_val  = c_off_load;
                end else begin
                    w_timer_dec = 1'b1;
                end
            end
            S_GAP: begin
                w_timer_dec = !w_timer_zero;
            end
            default: ;
        endcase
    end

    // Playback FSM with registered outputs; reset beats abort beats start.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            limit_q       <= '0;
            rom_address_q <= '0;
            leds_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else if (bus.abort && (state_q != S_IDLE)) begin
            state_q       <= S_IDLE;
            rom_address_q <= '0;
            leds_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        limit_q       <= bus.limit;
                        rom_address_q <= '0;
                        busy_q        <= 1'b1;
                        state_q       <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state_q <= S_LOAD;
                end
                S_LOAD: begin
                    leds_q  <= bus.rom_data;
                    state_q <= S_SHOW;
                end
                S_SHOW: begin
                    if (w_timer_zero) begin
                        leds_q  <= '0;
                        state_q <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (w_timer_zero) begin
                        if (rom_address_q == limit_q) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            rom_address_q <= rom_address_d;
                            state_q       <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rom_address = rom_address_q;
    assign bus.leds        = leds_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule : rom_sequence_player
`default_nettype wire

// File: tb/tb_rom_sequence_player.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rom_sequence_player
//  Brief    : Directed self-checking bench for rom_sequence_player + ROM.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rom_sequence_player;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [6:0] pat [16];

    always #5 clock = ~clock;

    rom_sequence_player_if bus ();

    rom_sequence_player #(
        .ON_CYCLES   (4),
        .OFF_CYCLES  (2),
        .TIMER_WIDTH (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    sync_rom_16x4 u_rom (
        .clock    (clock),
        .address  (bus.rom_address),
        .data_out (bus.rom_data)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected outputs after edge k of a playback of lim (edge 0 = start edge).
    task automatic expect_cycle(input int lim, input int k);
        int         last;
        int         s;
        int         p;
        logic [6:0] e_leds;
        logic [3:0] e_addr;
        logic       e_busy;
        logic       e_done;
        last = 8 * (lim + 1);
        if (k < last) begin
            s      = k / 8;
            p      = k % 8;
            e_leds = (p >= 2 && p <= 5) ? pat[s] : 7'd0;
            e_addr = 4'(s);
            e_busy = 1'b1;
            e_done = 1'b0;
        end else if (k == last) begin
            e_leds = 7'd0;
            e_addr = 4'(lim);
            e_busy = 1'b1;
            e_done = 1'b1;
        end else begin
            e_leds = 7'd0;
            e_addr = 4'(lim);
            e_busy = 1'b0;
            e_done = 1'b0;
        end
        chk($sformatf("leds_L%0d_k%0d", lim, k), 32'(bus.leds), 32'(e_leds));
        chk($sformatf("addr_L%0d_k%0d", lim, k), 32'(bus.rom_address), 32'(e_addr));
        chk($sformatf("busy_L%0d_k%0d", lim, k), 32'(bus.busy), 32'(e_busy));
        chk($sformatf("done_L%0d_k%0d", lim, k), 32'(bus.done), 32'(e_done));
    endtask

    // kind: 0 none, 1 restart with limit 0, 2 abort, 3 reset; injected after edge inj_k.
    task automatic run_seq(input int lim, input int kind, input int inj_k);
        int last;
        last = 8 * (lim + 1);
        @(negedge clock);
        bus.limit = 4'(lim);
        bus.start = 1'b1;
        for (int k = 0; k <= last + 1; k++) begin
            @(posedge clock);
            #1;
            bus.start = 1'b0;
            bus.abort = 1'b0;
            reset     = 1'b1;
            @(negedge clock);
            if (kind >= 2 && k == inj_k + 1) begin
                chk($sformatf("stop%0d_leds", kind), 32'(bus.leds), 32'd0);
                chk($sformatf("stop%0d_busy", kind), 32'(bus.busy), 32'd0);
                chk($sformatf("stop%0d_addr", kind), 32'(bus.rom_address), 32'd0);
                chk($sformatf("stop%0d_done", kind), 32'(bus.done), 32'd0);
                break;
            end
            expect_cycle(lim, k);
            if (k == inj_k) begin
                case (kind)
                    1: begin
                        bus.start = 1'b1;
                        bus.limit = 4'd0;
                    end
                    2: bus.abort = 1'b1;
                    3: reset = 1'b0;
                    default: ;
                endcase
            end
        end
        if (kind == 2) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge clock);
                chk("post_abort_done", 32'(bus.done), 32'd0);
                chk("post_abort_busy", 32'(bus.busy), 32'd0);
            end
        end
    endtask

    initial begin
        pat = '{7'b0000001, 7'b0000010, 7'b0000100, 7'b0001000,
                7'b0010000, 7'b0100000, 7'b1000000, 7'b0100000,
                7'b0010000, 7'b0001000, 7'b0000100, 7'b0000010,
                7'b0000001, 7'b0000010, 7'b0001000, 7'b0000100};
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.limit = 4'd0;
        reset     = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_leds", 32'(bus.leds), 32'd0);
        chk("rst_addr", 32'(bus.rom_address), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        reset = 1'b1;

        run_seq(0, 0, -1);
        run_seq(3, 0, -1);
        run_seq(15, 0, -1);
        run_seq(1, 0, -1);
        run_seq(3, 1, 11);   // restart attempt during SHOW of step 1
        run_seq(5, 2, 19);   // abort during SHOW of step 2
        run_seq(3, 3, 14);   // reset during GAP of step 1
        run_seq(0, 0, -1);

        // abort together with start in IDLE keeps the block idle
        @(negedge clock);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        bus.limit = 4'd2;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("idle_abort_busy", 32'(bus.busy), 32'd0);
            chk("idle_abort_leds", 32'(bus.leds), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_rom_sequence_player
`default_nettype wire
